tara_controller: RTL and testbench

Sequences tare acquisition for the weighing datapath. The block holds the active tare value, which resets to the fixed factory tare of 40. On operator request it captures a stable gross-weight reading as the new tare. Every valid gross sample produces a registered net weight (gross − tare). It sits between the ADC/weight-sample stage and the display/BCD stage.

---
 rtl/balanca_pkg.sv | 14 +
 rtl/detetor_flanco.sv | 25 ++
 rtl/tara_controller.sv | 162 ++++++++++++++++
 tb/tb_tara_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/balanca_pkg.sv
// Shared definitions for the weighing datapath.
// Sample width, factory tare and tare-acquisition FSM states.
package balanca_pkg;

    localparam int W = 12;
    localparam logic [W-1:0] TARA_DEFAULT = 12'd40;

    typedef enum logic [1:0] {
        IDLE,
        REF,
        CHECK
    } estado_t;

endpackage

// File: rtl/detetor_flanco.sv
// Rising-edge detector for debounced operator buttons.
// Emits a one-cycle registered pulse on a 0->1 transition.
module detetor_flanco (
    input  logic clk,
    input  logic rst,
    input  logic sinal,
    output logic flanco
);

    logic prev_q;
    logic flanco_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q   <= 1'b0;
            flanco_q <= 1'b0;
        end else begin
            prev_q   <= sinal;
            flanco_q <= sinal & ~prev_q;
        end
    end

    assign flanco = flanco_q;

endmodule

// File: rtl/tara_controller.sv
// Tare acquisition sequencer and net-weight path.
// Captures a stable gross reading as tare; nets every valid sample.
module tara_controller
    import balanca_pkg::*;
#(
    parameter int N_STABLE    = 4,
    parameter int TOL         = 2,
    parameter int MAX_SAMPLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] peso_bruto,
    input  logic         peso_valido,
    input  logic         btn_tara,
    input  logic         btn_limpa,
    output logic [W-1:0] taracabo,
    output logic [W-1:0] peso_liquido,
    output logic         liquido_valido,
    output logic         negativo,
    output logic         ocupado,
    output logic         tara_ok,
    output logic         tara_erro
);

    localparam int CW = $clog2(MAX_SAMPLES + 1);

    logic req_tara;
    logic req_limpa;

    estado_t      state_q, state_d;
    logic [W-1:0] ref_q, ref_d;
    logic [CW-1:0] samp_q, samp_d;
    logic [CW-1:0] stab_q, stab_d;
    logic [W-1:0] tara_q, tara_d;
    logic         ok_q, ok_d;
    logic         erro_q, erro_d;
    logic [W-1:0] liq_q, liq_d;
    logic         neg_q, neg_d;
    logic         lv_q;
    logic [W-1:0] dev;

    detetor_flanco u_flanco_tara (
        .clk    (clk),
        .rst    (rst),
        .sinal  (btn_tara),
        .flanco (req_tara)
    );

    detetor_flanco u_flanco_limpa (
        .clk    (clk),
        .rst    (rst),
        .sinal  (btn_limpa),
        .flanco (req_limpa)
    );

    // Magnitude as larger minus smaller, so it never wraps
    assign dev = (peso_bruto >= ref_q) ? (peso_bruto - ref_q)
                                       : (ref_q - peso_bruto);

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        samp_d  = samp_q;
        stab_d  = stab_q;
        tara_d  = tara_q;
        ok_d    = 1'b0;
        erro_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_tara) begin
                    state_d = REF;
                    samp_d  = '0;
                    stab_d  = '0;
                end
            end
            REF: begin
                if (peso_valido) begin
                    ref_d   = peso_bruto;
                    samp_d  = CW'(1);
                    stab_d  = CW'(1);
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (peso_valido) begin
                    samp_d = samp_q + CW'(1);
                    if (dev <= W'(TOL)) begin
                        stab_d = stab_q + CW'(1);
                    end else begin
                        ref_d  = peso_bruto;
                        stab_d = CW'(1);
                    end
                    if (stab_d == CW'(N_STABLE)) begin
                        tara_d  = ref_d;
                        ok_d    = 1'b1;
                        state_d = IDLE;
                    end else if (samp_d == CW'(MAX_SAMPLES)) begin
                        erro_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Clear overrides everything, including a same-cycle tare request
        if (req_limpa) begin
            state_d = IDLE;
            tara_d  = TARA_DEFAULT;
            ok_d    = 1'b0;
            erro_d  = 1'b0;
        end
    end

    always_comb begin
        liq_d = liq_q;
        neg_d = neg_q;
        if (peso_valido) begin
            if (peso_bruto >= tara_q) begin
                liq_d = peso_bruto - tara_q;
                neg_d = 1'b0;
            end else begin
                liq_d = '0;
                neg_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ref_q   <= '0;
            samp_q  <= '0;
            stab_q  <= '0;
            tara_q  <= TARA_DEFAULT;
            ok_q    <= 1'b0;
            erro_q  <= 1'b0;
            liq_q   <= '0;
            neg_q   <= 1'b0;
            lv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            samp_q  <= samp_d;
            stab_q  <= stab_d;
            tara_q  <= tara_d;
            ok_q    <= ok_d;
            erro_q  <= erro_d;
            liq_q   <= liq_d;
            neg_q   <= neg_d;
            lv_q    <= peso_valido;
        end
    end

    assign taracabo       = tara_q;
    assign peso_liquido   = liq_q;
    assign liquido_valido = lv_q;
    assign negativo       = neg_q;
    assign ocupado        = (state_q != IDLE);
    assign tara_ok        = ok_q;
    assign tara_erro      = erro_q;

endmodule

// File: tb/tb_tara_controller.sv
// Directed bench for tara_controller: net path, tare commit/abort,
// clear and reset behaviour, with immediate-assertion checks.
module tb_tara_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] peso_bruto;
    logic        peso_valido;
    logic        btn_tara;
    logic        btn_limpa;
    logic [11:0] taracabo;
    logic [11:0] peso_liquido;
    logic        liquido_valido;
    logic        negativo;
    logic        ocupado;
    logic        tara_ok;
    logic        tara_erro;

    int total = 0;
    int bad   = 0;

    tara_controller #(
        .N_STABLE    (4),
        .TOL         (2),
        .MAX_SAMPLES (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .peso_bruto     (peso_bruto),
        .peso_valido    (peso_valido),
        .btn_tara       (btn_tara),
        .btn_limpa      (btn_limpa),
        .taracabo       (taracabo),
        .peso_liquido   (peso_liquido),
        .liquido_valido (liquido_valido),
        .negativo       (negativo),
        .ocupado        (ocupado),
        .tara_ok        (tara_ok),
        .tara_erro      (tara_erro)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one valid sample; returns on the negedge after capture
    task automatic sample(input logic [11:0] v);
        @(negedge clk);
        peso_bruto  = v;
        peso_valido = 1'b1;
        @(negedge clk);
        peso_valido = 1'b0;
    endtask

    task automatic press(input logic t, input logic l);
        @(negedge clk);
        btn_tara  = t;
        btn_limpa = l;
        @(negedge clk);
        @(negedge clk);
        btn_tara  = 1'b0;
        btn_limpa = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".tara"}, 32'(taracabo), 40);
        chk({tag, ".liq"}, 32'(peso_liquido), 0);
        chk({tag, ".lv"}, 32'(liquido_valido), 0);
        chk({tag, ".neg"}, 32'(negativo), 0);
        chk({tag, ".ocup"}, 32'(ocupado), 0);
        chk({tag, ".ok"}, 32'(tara_ok), 0);
        chk({tag, ".erro"}, 32'(tara_erro), 0);
    endtask

    initial begin
        rst         = 1'b1;
        peso_bruto  = '0;
        peso_valido = 1'b0;
        btn_tara    = 1'b0;
        btn_limpa   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset("rst");

        sample(12'd100);
        chk("net100.lv", 32'(liquido_valido), 1);
        chk("net100.liq", 32'(peso_liquido), 60);
        chk("net100.neg", 32'(negativo), 0);
        @(negedge clk);
        chk("net100.lv_drop", 32'(liquido_valido), 0);

        sample(12'd25);
        chk("net25.liq", 32'(peso_liquido), 0);
        chk("net25.neg", 32'(negativo), 1);

        press(1'b1, 1'b0);
        chk("tare200.ocup", 32'(ocupado), 1);
        sample(12'd200);
        sample(12'd201);
        sample(12'd199);
        chk("tare200.no_ok_yet", 32'(tara_ok), 0);
        sample(12'd200);
        chk("tare200.ok", 32'(tara_ok), 1);
        chk("tare200.tara", 32'(taracabo), 200);
        chk("tare200.ocup_drop", 32'(ocupado), 0);
        chk("tare200.old_net", 32'(peso_liquido), 160);
        @(negedge clk);
        chk("tare200.ok_pulse", 32'(tara_ok), 0);
        sample(12'd250);
        chk("net250.liq", 32'(peso_liquido), 50);

        press(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) begin
            sample((i % 2 == 0) ? 12'd100 : 12'd110);
            chk("alt.no_erro", 32'(tara_erro), 0);
        end
        chk("alt.ocup_mid", 32'(ocupado), 1);
        sample(12'd110);
        chk("alt.erro", 32'(tara_erro), 1);
        chk("alt.ok", 32'(tara_ok), 0);
        chk("alt.tara", 32'(taracabo), 200);
        chk("alt.ocup", 32'(ocupado), 0);
        @(negedge clk);
        chk("alt.erro_pulse", 32'(tara_erro), 0);

        press(1'b1, 1'b1);
        chk("both.tara", 32'(taracabo), 40);
        chk("both.ocup", 32'(ocupado), 0);
        chk("both.ok", 32'(tara_ok), 0);
        chk("both.erro", 32'(tara_erro), 0);

        press(1'b1, 1'b0);
        sample(12'd500);
        sample(12'd500);
        chk("mid.ocup", 32'(ocupado), 1);
        press(1'b0, 1'b1);
        chk("mid.ocup_clr", 32'(ocupado), 0);
        chk("mid.tara", 32'(taracabo), 40);
        chk("mid.ok", 32'(tara_ok), 0);
        sample(12'd500);
        chk("mid.no_commit", 32'(tara_ok), 0);
        chk("mid.net", 32'(peso_liquido), 460);

        press(1'b1, 1'b0);
        sample(12'd300);
        sample(12'd300);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("rstmid");

        press(1'b1, 1'b0);
        repeat (4) sample(12'd300);
        chk("tare300.ok", 32'(tara_ok), 1);
        chk("tare300.tara", 32'(taracabo), 300);
        sample(12'd350);
        chk("net350.liq", 32'(peso_liquido), 50);
        chk("net350.neg", 32'(negativo), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
